// File: rtl/candidate_best_select_pkg.sv
// Shared constants for candidate_best_select: width derivation, FSM encoding, cost saturation.
package candidate_best_select_pkg;

    function automatic int awidth_f(input int a);
        return $clog2(a) + 1;
    endfunction

    function automatic int sumw_f(input int j, input int cw);
        return cw + $clog2(j) + 1;
    endfunction

    // Cost charged for an out-of-alphabet symbol: all ones at the per-symbol width.
    function automatic logic [31:0] cost_sat_f(input int cw);
        return (32'd1 << cw) - 32'd1;
    endfunction

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACC   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/candidate_best_select_if.sv
// Row stream, cost table load and best-result bus of candidate_best_select.
// Optional second_cost signal present when CAND_SEL_SECOND_BEST_EN is defined.
interface candidate_best_select_if #(
    parameter int J    = 14,
    parameter int A    = 2,
    parameter int CW   = 8,
    parameter int IDXW = 16
) ();
    import candidate_best_select_pkg::*;

    localparam int AWIDTH = awidth_f(A);
    localparam int SUMW   = sumw_f(J, CW);

    logic [J*A*CW-1:0]     cost_table;
    logic                  cost_table_tvalid;
    logic [J*AWIDTH-1:0]   candidate_row;
    logic                  candidate_row_tvalid;
    logic                  candidate_row_tlast;
    logic [J*AWIDTH-1:0]   best_row;
    logic [SUMW-1:0]       best_cost;
    logic [IDXW-1:0]       best_index;
    logic                  best_tvalid;
    logic                  busy;
`ifdef CAND_SEL_SECOND_BEST_EN
    logic [SUMW-1:0]       second_cost;
`endif

    modport master (
        output cost_table, cost_table_tvalid, candidate_row, candidate_row_tvalid,
               candidate_row_tlast,
        input  best_row, best_cost, best_index, best_tvalid, busy
`ifdef CAND_SEL_SECOND_BEST_EN
        , second_cost
`endif
    );

    modport slave (
        input  cost_table, cost_table_tvalid, candidate_row, candidate_row_tvalid,
               candidate_row_tlast,
        output best_row, best_cost, best_index, best_tvalid, busy
`ifdef CAND_SEL_SECOND_BEST_EN
        , second_cost
`endif
    );

endinterface

// File: rtl/candidate_best_select_cost_sum.sv
// cand_cost_sum: S1 per-position cost lookup, S2 row-cost sum; an opaque tag rides alongside.
module cand_cost_sum
    import candidate_best_select_pkg::*;
#(
    parameter int J      = 14,
    parameter int A      = 2,
    parameter int CW     = 8,
    parameter int TW     = 1,
    parameter int AWIDTH = awidth_f(A),
    parameter int SUMW   = sumw_f(J, CW)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [J*A*CW-1:0]   cost_table,
    input  logic [J*AWIDTH-1:0] in_row,
    input  logic                in_vld,
    input  logic [TW-1:0]       in_tag,
    output logic                out_vld,
    output logic [SUMW-1:0]     out_sum,
    output logic [TW-1:0]       out_tag,
    output logic                pipe_busy
);

    localparam logic [CW-1:0] COST_SAT = CW'(cost_sat_f(CW));

    logic [CW-1:0]   cost_d [J];
    logic [CW-1:0]   s1_cost_q [J];
    logic [TW-1:0]   s1_tag_q;
    logic            s1_vld_q;
    logic [SUMW-1:0] sum_d;
    logic [SUMW-1:0] s2_sum_q;
    logic [TW-1:0]   s2_tag_q;
    logic            s2_vld_q;

    // NOTE: every always_comb output gets a default before any condition, so no latch can form.
    always_comb begin
        for (int j = 0; j < J; j++) begin
            cost_d[j] = COST_SAT;
            if (int'(in_row[j*AWIDTH +: AWIDTH]) < A)
                cost_d[j] = cost_table[(j*A + int'(in_row[j*AWIDTH +: AWIDTH]))*CW +: CW];
        end
    end

    always_comb begin
        sum_d = '0;
        for (int j = 0; j < J; j++)
            sum_d = sum_d + SUMW'(s1_cost_q[j]);
    end

    // NOTE: sequential state uses <= so all flops sample the pre-edge values together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
        end else begin
            s1_vld_q <= in_vld;
            s2_vld_q <= s1_vld_q;
        end
    end

    // NOTE: data registers are left unreset; they are only ever consumed under their valid.
    always_ff @(posedge clk) begin
        s1_cost_q <= cost_d;
        s1_tag_q  <= in_tag;
        s2_sum_q  <= sum_d;
        s2_tag_q  <= s1_tag_q;
    end

    assign out_vld   = s2_vld_q;
    assign out_sum   = s2_sum_q;
    assign out_tag   = s2_tag_q;
    assign pipe_busy = s1_vld_q | s2_vld_q;

endmodule

// File: rtl/candidate_best_select.sv
// candidate_best_select: tracks the lowest-cost candidate row per batch and reports it.
// Define CAND_SEL_SECOND_BEST_EN to also report the second-lowest row cost.
module candidate_best_select
    import candidate_best_select_pkg::*;
#(
    parameter int J    = 14,
    parameter int A    = 2,
    parameter int CW   = 8,
    parameter int IDXW = 16
) (
    input logic                    clk,
    input logic                    rst,
    candidate_best_select_if.slave bus
);

    localparam int AWIDTH = awidth_f(A);
    localparam int SUMW   = sumw_f(J, CW);
    localparam int ROWW   = J * AWIDTH;
    localparam int TW     = 2 + IDXW + ROWW;

    logic [1:0]        state_q, state_d;
    logic              drain_q, drain_d;
    logic [IDXW-1:0]   cnt_q, cnt_d;
    logic [J*A*CW-1:0] table_q, table_d;

    logic [TW-1:0]     in_tag, s2_tag;
    logic              s2_vld, s2_last, s2_first, pipe_busy, take;
    logic [SUMW-1:0]   s2_cost;
    logic [IDXW-1:0]   s2_idx;
    logic [ROWW-1:0]   s2_row;

    logic [SUMW-1:0]   best_cost_q, best_cost_d, out_cost_q, out_cost_d;
    logic [ROWW-1:0]   best_row_q, best_row_d, out_row_q, out_row_d;
    logic [IDXW-1:0]   best_idx_q, best_idx_d, out_idx_q, out_idx_d;
    logic              out_vld_q, out_vld_d;
`ifdef CAND_SEL_SECOND_BEST_EN
    logic [SUMW-1:0]   sec_q, sec_d, out_sec_q, out_sec_d;
`endif

    wire row_vld  = bus.candidate_row_tvalid;
    wire row_last = bus.candidate_row_tlast;

    // Row symbols, batch index and first/last markers travel with the cost.
    assign in_tag = {row_last, (cnt_q == '0), cnt_q, bus.candidate_row};
    assign {s2_last, s2_first, s2_idx, s2_row} = s2_tag;

    cand_cost_sum #(
        .J(J), .A(A), .CW(CW), .TW(TW), .AWIDTH(AWIDTH), .SUMW(SUMW)
    ) u_cost_sum (
        .clk       (clk),
        .rst       (rst),
        .cost_table(table_q),
        .in_row    (bus.candidate_row),
        .in_vld    (row_vld),
        .in_tag    (in_tag),
        .out_vld   (s2_vld),
        .out_sum   (s2_cost),
        .out_tag   (s2_tag),
        .pipe_busy (pipe_busy)
    );

    always_comb begin
        cnt_d   = cnt_q;
        table_d = table_q;
        if (row_vld)
            cnt_d = row_last ? '0 : ((cnt_q == '1) ? cnt_q : cnt_q + IDXW'(1));
        if (bus.cost_table_tvalid && state_q == ST_IDLE && !pipe_busy)
            table_d = bus.cost_table;
    end

    // A row in DRAIN/DONE opens a new batch; the old result still leaves via the pipeline.
    always_comb begin
        state_d = state_q;
        drain_d = 1'b0;
        if (row_vld) begin
            if (row_last)
                state_d = ST_DRAIN;
            else if (state_q != ST_ACC)
                state_d = ST_ACC;
        end else begin
            case (state_q)
                ST_DRAIN: begin
                    drain_d = 1'b1;
                    if (drain_q) state_d = ST_DONE;
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        take        = s2_first || (s2_cost < best_cost_q);
        best_cost_d = best_cost_q;
        best_row_d  = best_row_q;
        best_idx_d  = best_idx_q;
        if (s2_vld && take) begin
            best_cost_d = s2_cost;
            best_row_d  = s2_row;
            best_idx_d  = s2_idx;
        end
        out_vld_d  = s2_vld && s2_last;
        out_cost_d = out_vld_d ? best_cost_d : out_cost_q;
        out_row_d  = out_vld_d ? best_row_d  : out_row_q;
        out_idx_d  = out_vld_d ? best_idx_d  : out_idx_q;
`ifdef CAND_SEL_SECOND_BEST_EN
        sec_d = sec_q;
        if (s2_vld) begin
            if (s2_first)
                sec_d = '1;
            else if (take)
                sec_d = best_cost_q;
            else if (s2_cost < sec_q)
                sec_d = s2_cost;
        end
        out_sec_d = out_vld_d ? sec_d : out_sec_q;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            drain_q     <= 1'b0;
            cnt_q       <= '0;
            table_q     <= '0;
            best_cost_q <= '1;
            best_row_q  <= '0;
            best_idx_q  <= '0;
            out_cost_q  <= '1;
            out_row_q   <= '0;
            out_idx_q   <= '0;
            out_vld_q   <= 1'b0;
`ifdef CAND_SEL_SECOND_BEST_EN
            sec_q       <= '1;
            out_sec_q   <= '1;
`endif
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            cnt_q       <= cnt_d;
            table_q     <= table_d;
            best_cost_q <= best_cost_d;
            best_row_q  <= best_row_d;
            best_idx_q  <= best_idx_d;
            out_cost_q  <= out_cost_d;
            out_row_q   <= out_row_d;
            out_idx_q   <= out_idx_d;
            out_vld_q   <= out_vld_d;
`ifdef CAND_SEL_SECOND_BEST_EN
            sec_q       <= sec_d;
            out_sec_q   <= out_sec_d;
`endif
        end
    end

    assign bus.best_row    = out_row_q;
    assign bus.best_cost   = out_cost_q;
    assign bus.best_index  = out_idx_q;
    assign bus.best_tvalid = out_vld_q;
    assign bus.busy        = (state_q != ST_IDLE);
`ifdef CAND_SEL_SECOND_BEST_EN
    assign bus.second_cost = out_sec_q;
`endif

endmodule

// File: doc/candidate_best_select.md
CANDIDATE_BEST_SELECT -- requirements
Module: candidate_best_select

Interface
REQ-001 Parameters: J, default 14, number of symbol positions per row; A, default 2, alphabet size; CW, default 8, per-symbol cost width; IDXW, default 16, row-index width.
REQ-002 Derived constants: AWIDTH = $clog2(A)+1; SUMW = CW+$clog2(J)+1.
REQ-003 clk  input  1  single clock; all state rising-edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 cost_table  input  J*A*CW  per-position, per-symbol cost; entry (j,a) at bits [(j*A+a)*CW +: CW].
REQ-006 cost_table_tvalid  input  1  captures cost_table into an internal register.
REQ-007 candidate_row  input  J*AWIDTH  candidate symbols; position j at [j*AWIDTH +: AWIDTH].
REQ-008 candidate_row_tvalid  input  1  row valid; no backpressure, every valid row is consumed.
REQ-009 candidate_row_tlast  input  1  marks last row of a batch; qualified by tvalid.
REQ-010 best_row  output  J*AWIDTH  lowest-cost row of the finished batch.
REQ-011 best_cost  output  SUMW  cost of best_row.
REQ-012 best_index  output  IDXW  zero-based batch position of best_row.
REQ-013 best_tvalid  output  1  one-cycle pulse; result outputs stable until next pulse.
REQ-014 busy  output  1  high from first accepted row of a batch until the best_tvalid cycle inclusive.

Function
REQ-015 Row cost = sum over j of cost_table entry (j, symbol_j); symbol value >= A contributes 2^CW-1.
REQ-016 Pipeline: S1 registers J looked-up costs; S2 registers SUMW-bit sum; S3 compares and updates best registers; no overflow possible at SUMW.
REQ-017 Row accepted in cycle t updates best registers at edge t+3; tlast row at t gives best_tvalid high in cycle t+3.
REQ-018 Row index counter starts at 0 per batch, increments per accepted row, saturates at 2^IDXW-1 (saturated index reported as-is).
REQ-019 First row of a batch loads best unconditionally; later rows replace best only if cost strictly less (ties keep earlier row).
REQ-020 State machine IDLE -> ACC on first valid row; ACC -> DRAIN on valid tlast; DRAIN -> DONE after 2 cycles; DONE pulses best_tvalid, -> IDLE.
REQ-021 A valid row arriving in DRAIN or DONE starts a new batch without gap; its pipeline slot is independent, the finishing batch's result is unaffected.
REQ-022 tvalid with tlast on first row: single-row batch, best_index 0.
REQ-023 cost_table_tvalid captured only when busy is low and no row is in the pipeline; otherwise ignored.
REQ-024 Row, cost and index travel together through S1-S3 so best_row always matches best_cost.

Reset
REQ-025 rst asserted: state IDLE, pipeline valids 0, cost table 0, best_row 0, best_cost all ones, best_index 0, best_tvalid 0, busy 0.
REQ-026 rst mid-batch aborts it; no best_tvalid for the aborted batch; first valid row after release starts index 0.

Configuration
REQ-027 Macro CAND_SEL_SECOND_BEST_EN defined: extra output second_cost (SUMW) = second-lowest row cost of batch (all ones if batch has one row), valid with best_tvalid; undefined: port and logic absent, all other behaviour identical.

Structure
REQ-028 Shared package holds AWIDTH/SUMW derivation functions, state encoding, and cost saturation constant.
REQ-029 One sub-module cand_cost_sum (lookup plus registered adder tree, S1-S2); compare/FSM stays in top.

Verification
REQ-030 J=14, A=2, cost(j,1)=j+1, cost(j,0)=0; rows all-0, all-1, one-hot pos 3, tlast on third -> best_cost 0, best_index 0, pulse 3 cycles after tlast.
REQ-031 Two rows of equal cost 5, tlast on second -> best_index 0 (tie keeps first).
REQ-032 Back-to-back batches, second batch first row in cycle after tlast -> two pulses, each with its own best, no cross-contamination.
REQ-033 rst asserted during ACC after 4 rows, then 2-row batch -> only one pulse, best_index in {0,1}.
REQ-034 Symbol value 3 with A=2 at any position -> that row cost >= 255, never selected over a legal row of cost <255.
REQ-035 With CAND_SEL_SECOND_BEST_EN, row costs 9, 4, 7 -> best_cost 4, second_cost 7, best_index 1.
